asg_seq_ctrl: RTL and testbench
===============================

Name: asg_seq_ctrl

Overview:
Segment sequencer for one ASG channel. It holds a table of up to NSEG waveform segments, each with offset, size, step and cycle count. It drives the channel's set_ofs/set_size/set_step inputs, reset and software trigger, then counts wrap events from trig_done to advance through the segments. It sits between the ASG register bank and the channel FSM, on the DAC clock domain.

Parameters:
RSZ, 14, channel buffer address width; pointer fields are RSZ+16 bits
NSEG, 8, segment table depth (power of two)
SEG_AW, 3, log2(NSEG)

Ports:
dac_clk_i  in  1  DAC clock
dac_rstn_i  in  1  reset, asynchronous, active-low
cfg_we_i  in  1  table write strobe
cfg_addr_i  in  SEG_AW+2  {segment, field}; field 0=ofs, 1=size, 2=step, 3=ncyc
cfg_wdata_i  in  32  write data; fields 0-2 use the low RSZ+16 bits
seq_len_i  in  SEG_AW+1  number of active segments, 0..NSEG
seq_loop_i  in  1  restart at segment 0 after the last segment
start_i  in  1  start pulse
stop_i  in  1  abort pulse
trig_done_i  in  1  channel wrap/trigger event
set_ofs_o  out  RSZ+16  to channel
set_size_o  out  RSZ+16  to channel
set_step_o  out  RSZ+16  to channel
set_rst_o  out  1  channel FSM reset
trig_sw_o  out  1  channel software trigger (channel trig_src must be 1)
busy_o  out  1  sequence active
seg_idx_o  out  SEG_AW  current segment
done_o  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset (async): state IDLE. All outputs, idx and wrap counter are 0. Table contents are undefined; no reset is required on the RAM.
- Table writes land one cycle after cfg_we_i and are accepted in any state. A change to a segment takes effect at that segment's next LOAD.
- IDLE:
  - start_i with seq_len_i!=0 -> LOAD with idx=0.
  - start_i with seq_len_i==0 is ignored.
  - busy_o=0.
- LOAD (1 cycle): register table[idx] into set_*_o and ncyc_r. ncyc==0 is treated as 1. Next state RST.
- RST (1 cycle): set_rst_o=1. Next state ARM.
- ARM (1 cycle): trig_sw_o=1. Clear the wrap counter. Next state RUN.
- RUN:
  - Hold set_rst_o=0 and trig_sw_o=0.
  - trig_done_i is ignored during the first 2 RUN cycles (blanking for the channel's trigger-echo term).
  - After blanking, each cycle with trig_done_i=1 increments the wrap counter (32 bits).
  - When trig_done_i=1 and counter==ncyc_r-1, the segment ends:
    - If idx<seq_len_i-1: idx+1, go to LOAD.
    - Else if seq_loop_i: idx=0, go to LOAD.
    - Else go to DONE.
- DONE (1 cycle): set_rst_o=1, done_o=1. Next state IDLE.
- busy_o=1 in every state except IDLE. seg_idx_o=idx, registered.
- stop_i has priority over everything in every non-IDLE state. Next cycle: state IDLE, set_rst_o=1 for exactly that one cycle, done_o=0, idx=0.
  - stop_i in IDLE has no effect.
  - stop_i and start_i in the same cycle: stop wins.
- start_i while busy is ignored.
- seq_len_i is sampled live at each segment end. If it shrinks below idx+1, the segment end is treated as the last segment.
- Segment-to-segment gap: exactly 3 cycles (LOAD, RST, ARM) from the terminal trig_done_i to the next trig_sw_o, so trig_sw_o is asserted 3 cycles after the terminal trig_done_i.
- set_*_o hold their values in IDLE after a sequence ends.

Optional Feature:
ASG_SEQ_EXT_TRIG_EN
- Defined:
  - Adds input ext_trig_i (1 bit, synchronous) and a per-segment gate bit: cfg_wdata_i[31] on the field-3 write.
  - For a gated segment, ARM holds until ext_trig_i is sampled rising (0 then 1 on consecutive cycles). trig_sw_o pulses in the cycle the edge is detected.
  - stop_i still aborts while waiting.
  - For a gated segment, ncyc is cfg_wdata_i[30:0].
- Undefined: no port, bit 31 is part of ncyc, and ARM is always 1 cycle.

Test Plan:
- Single segment, no loop: seg0={ofs=0, size=0x3FFF_FFFF, step=0x10000, ncyc=2}, seq_len=1, start -> set_rst_o at LOAD+1, trig_sw_o at LOAD+2. Drive trig_done_i twice after blanking -> DONE with set_rst_o=1 and done_o=1 in the same cycle; busy_o falls the next cycle.
- Three segments, ncyc={1,3,2}, loop=0: seg_idx_o steps 0->1->2 after 1, 3 and 2 counted wraps. trig_done_i pulses during the 2 blanking cycles are not counted. Gap is 3 cycles per transition.
- Loop: seq_len=2, loop=1 -> after seg1 ends, idx returns to 0 and LOAD repeats. done_o never pulses over 5 loops.
- stop_i mid-RUN of seg1 -> next cycle IDLE, set_rst_o=1 for 1 cycle, done_o=0, busy_o=0. A start_i in the same cycle as stop_i is ignored.
- Edge cases:
  - seq_len=0 with start_i -> stays IDLE.
  - ncyc=0 -> behaves as 1.
  - Writing seg1 ofs=0x1234_0000 during seg0 RUN -> set_ofs_o=0x1234_0000 at seg1 LOAD.
- Async reset asserted mid-RUN -> all outputs 0 immediately without waiting for a clock edge. After release, state is IDLE.

Source files
------------

// File: rtl/asg_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : asg_seq_ctrl
// Purpose  : Segment sequencer for one ASG channel. It holds a table of NSEG
//            segments (offset, size, step, cycle count) and plays them back.
//            For each segment it drives the channel set_* inputs, resets the
//            channel, issues a software trigger and then counts trig_done
//            wrap events to decide when to move on to the next segment.
// Option   : ASG_SEQ_EXT_TRIG_EN adds ext_trig_i and a per-segment gate bit
//            (bit 31 of the ncyc word). A gated segment waits in ARM for a
//            rising edge on ext_trig_i.
// Revision : 1.0 - initial release
// ============================================================================
module asg_seq_ctrl #(
  parameter int RSZ    = 14,
  parameter int NSEG   = 8,
  parameter int SEG_AW = 3
) (
  input  logic                dac_clk_i,
  input  logic                dac_rstn_i,
  input  logic                cfg_we_i,
  input  logic [SEG_AW+1:0]   cfg_addr_i,
  input  logic [31:0]         cfg_wdata_i,
  input  logic [SEG_AW:0]     seq_len_i,
  input  logic                seq_loop_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                trig_done_i,
`ifdef ASG_SEQ_EXT_TRIG_EN
  input  logic                ext_trig_i,
`endif
  output logic [RSZ+15:0]     set_ofs_o,
  output logic [RSZ+15:0]     set_size_o,
  output logic [RSZ+15:0]     set_step_o,
  output logic                set_rst_o,
  output logic                trig_sw_o,
  output logic                busy_o,
  output logic [SEG_AW-1:0]   seg_idx_o,
  output logic                done_o
);

  localparam int PW = RSZ + 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RST  = 3'd2,
    S_ARM  = 3'd3,
    S_RUN  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Segment table (no reset: contents are only meaningful after software writes)
  logic [PW-1:0]  ofs_mem  [NSEG];
  logic [PW-1:0]  size_mem [NSEG];
  logic [PW-1:0]  step_mem [NSEG];
  logic [31:0]    ncyc_mem [NSEG];

  state_t           state, state_nxt;
  logic [SEG_AW-1:0] idx, idx_nxt;
  logic [31:0]      ncyc_r;
  logic [31:0]      wrap_cnt;
  logic [1:0]       blank_cnt;
  logic             abort_r, abort_nxt;
  logic             cnt_en;
  logic             seg_end;
  logic             last_seg;
  logic             arm_go;
  logic [SEG_AW-1:0] wr_seg;

  assign wr_seg = cfg_addr_i[SEG_AW+1:2];

`ifdef ASG_SEQ_EXT_TRIG_EN
  logic gate_mem [NSEG];
  logic gate_r;
  logic ext_d;

  // Table write port; bit 31 of the ncyc word is the external-trigger gate
  always_ff @(posedge dac_clk_i) begin
    if (cfg_we_i) begin
      case (cfg_addr_i[1:0])
        2'd0:    ofs_mem[wr_seg]  <= cfg_wdata_i[PW-1:0];
        2'd1:    size_mem[wr_seg] <= cfg_wdata_i[PW-1:0];
        2'd2:    step_mem[wr_seg] <= cfg_wdata_i[PW-1:0];
        default: begin
          ncyc_mem[wr_seg] <= {1'b0, cfg_wdata_i[30:0]};
          gate_mem[wr_seg] <= cfg_wdata_i[31];
        end
      endcase
    end
  end

  // External trigger history for rising-edge detection, plus latched gate bit
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      ext_d  <= 1'b0;
      gate_r <= 1'b0;
    end else begin
      ext_d <= ext_trig_i;
      if (state == S_LOAD) gate_r <= gate_mem[idx];
    end
  end

  assign arm_go = !gate_r || (ext_trig_i && !ext_d);
`else
  // Table write port; the full 32-bit word is the cycle count
  always_ff @(posedge dac_clk_i) begin
    if (cfg_we_i) begin
      case (cfg_addr_i[1:0])
        2'd0:    ofs_mem[wr_seg]  <= cfg_wdata_i[PW-1:0];
        2'd1:    size_mem[wr_seg] <= cfg_wdata_i[PW-1:0];
        2'd2:    step_mem[wr_seg] <= cfg_wdata_i[PW-1:0];
        default: ncyc_mem[wr_seg] <= cfg_wdata_i;
      endcase
    end
  end

  assign arm_go = 1'b1;
`endif

  // Wraps only count once the blanking window after the trigger has passed
  assign cnt_en   = (state == S_RUN) && (blank_cnt == 2'd2) && trig_done_i;
  assign seg_end  = cnt_en && (wrap_cnt == ncyc_r - 32'd1);
  // seq_len is sampled live so a shrinking length ends the sequence early
  assign last_seg = ({1'b0, idx} + {{SEG_AW{1'b0}}, 1'b1}) >= seq_len_i;

  // Next-state logic; stop overrides every transition outside IDLE
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    abort_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i && !stop_i && (seq_len_i != '0)) begin
          state_nxt = S_LOAD;
          idx_nxt   = '0;
        end
      end
      S_LOAD: state_nxt = S_RST;
      S_RST:  state_nxt = S_ARM;
      S_ARM:  if (arm_go) state_nxt = S_RUN;
      S_RUN: begin
        if (seg_end) begin
          if (!last_seg) begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_LOAD;
          end else if (seq_loop_i) begin
            idx_nxt   = '0;
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (stop_i && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      abort_nxt = 1'b1;
    end
  end

  // State, index and abort-pulse registers
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state   <= S_IDLE;
      idx     <= '0;
      abort_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      abort_r <= abort_nxt;
    end
  end

  // Segment parameter load, blanking counter and wrap counter
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      set_ofs_o  <= '0;
      set_size_o <= '0;
      set_step_o <= '0;
      ncyc_r     <= '0;
      wrap_cnt   <= '0;
      blank_cnt  <= '0;
    end else begin
      if (state == S_LOAD) begin
        set_ofs_o  <= ofs_mem[idx];
        set_size_o <= size_mem[idx];
        set_step_o <= step_mem[idx];
        ncyc_r     <= (ncyc_mem[idx] == 32'd0) ? 32'd1 : ncyc_mem[idx];
      end
      if (state == S_ARM) begin
        wrap_cnt  <= '0;
        blank_cnt <= '0;
      end else begin
        if ((state == S_RUN) && (blank_cnt != 2'd2)) blank_cnt <= blank_cnt + 2'd1;
        if (cnt_en) wrap_cnt <= wrap_cnt + 32'd1;
      end
    end
  end

  assign set_rst_o = abort_r || (state == S_RST) || (state == S_DONE);
  assign trig_sw_o = (state == S_ARM) && arm_go;
  assign done_o    = (state == S_DONE);
  assign busy_o    = (state != S_IDLE);
  assign seg_idx_o = idx;

endmodule
`default_nettype wire

// File: tb/tb_asg_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_asg_seq_ctrl
// Purpose  : Scoreboard bench for asg_seq_ctrl. The driver plays sequences
//            against a segment-table model and queues the expected channel
//            events (reset, trigger, done) with their cycle numbers; a
//            monitor pops and compares whenever the DUT raises one of them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asg_seq_ctrl;
  localparam int RSZ    = 14;
  localparam int NSEG   = 8;
  localparam int SEG_AW = 3;
  localparam int PW     = RSZ + 16;

  localparam logic [2:0] K_RST  = 3'b001;
  localparam logic [2:0] K_ARM  = 3'b010;
  localparam logic [2:0] K_DONE = 3'b101;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [SEG_AW+1:0] cfg_addr = '0;
  logic [31:0]       cfg_wdata = '0;
  logic [SEG_AW:0]   seq_len = '0;
  logic              seq_loop = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              trig_done = 1'b0;
  logic              ext_trig = 1'b0;
  logic [PW-1:0]     set_ofs, set_size, set_step;
  logic              set_rst, trig_sw, busy, done;
  logic [SEG_AW-1:0] seg_idx;

  asg_seq_ctrl #(.RSZ(RSZ), .NSEG(NSEG), .SEG_AW(SEG_AW)) dut (
    .dac_clk_i   (clk),
    .dac_rstn_i  (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .seq_len_i   (seq_len),
    .seq_loop_i  (seq_loop),
    .start_i     (start),
    .stop_i      (stop),
    .trig_done_i (trig_done),
`ifdef ASG_SEQ_EXT_TRIG_EN
    .ext_trig_i  (ext_trig),
`endif
    .set_ofs_o   (set_ofs),
    .set_size_o  (set_size),
    .set_step_o  (set_step),
    .set_rst_o   (set_rst),
    .trig_sw_o   (trig_sw),
    .busy_o      (busy),
    .seg_idx_o   (seg_idx),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]    kind;
    int            cyc;
    int            idx;
    logic [PW-1:0] ofs;
    logic [PW-1:0] size;
    logic [PW-1:0] step;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;

  // Reference segment table
  logic [PW-1:0] m_ofs  [NSEG];
  logic [PW-1:0] m_size [NSEG];
  logic [PW-1:0] m_step [NSEG];
  int unsigned   m_ncyc [NSEG];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_ev(input logic [2:0] k, input int c, input int i);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.idx  = i;
    e.ofs  = m_ofs[i];
    e.size = m_size[i];
    e.step = m_step[i];
    exp_q.push_back(e);
  endtask

  // Monitor: every reset/trigger/done the DUT raises must match the queue head
  always @(negedge clk) begin
    if (rst_n && (trig_sw || set_rst || done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {61'd0, done, trig_sw, set_rst}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ev_kind", {61'd0, done, trig_sw, set_rst}, {61'd0, mon_e.kind});
        chk("ev_cycle", cyc, mon_e.cyc);
        if (mon_e.kind == K_ARM) begin
          chk("arm_idx", seg_idx, mon_e.idx);
          chk("arm_ofs", set_ofs, mon_e.ofs);
          chk("arm_size", set_size, mon_e.size);
          chk("arm_step", set_step, mon_e.step);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic cfg_write(input int seg, input int field, input logic [31:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = (SEG_AW+2)'(seg * 4 + field);
    cfg_wdata = d;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic set_seg(input int seg, input logic [PW-1:0] o, input logic [PW-1:0] s,
                         input logic [PW-1:0] st, input int unsigned n);
    cfg_write(seg, 0, 32'(o));
    cfg_write(seg, 1, 32'(s));
    cfg_write(seg, 2, 32'(st));
    cfg_write(seg, 3, n);
    m_ofs[seg]  = o;
    m_size[seg] = s;
    m_step[seg] = st;
    m_ncyc[seg] = n;
  endtask

  // Play one sequence. stop_after>=0 aborts in RUN of the segment following
  // that many completed segments; wr_test rewrites seg1 ofs during seg0 RUN.
  task automatic run_seq(input int len, input bit lp, input int stop_after, input bit wr_test);
    int  idx, segs, a, ncy, cnt, i, c;
    bit  td, term;
    idx  = 0;
    segs = 0;
    @(negedge clk);
    seq_len  = (SEG_AW+1)'(len);
    seq_loop = lp;
    start    = 1'b1;
    push_ev(K_RST, cyc + 2, 0);
    push_ev(K_ARM, cyc + 3, 0);
    a = cyc + 3;
    @(negedge clk);
    start = 1'b0;
    forever begin
      wait_cyc(a);
      ncy  = (m_ncyc[idx] == 0) ? 1 : int'(m_ncyc[idx]);
      cnt  = 0;
      i    = 0;
      term = 1'b0;
      while (!term) begin
        @(negedge clk);
        trig_done = 1'b0;
        cfg_we    = 1'b0;
        if (i == 0) begin
          chk("run_busy", busy, 1);
          chk("run_idx", seg_idx, idx);
        end
        if (segs == stop_after && i == 3) begin
          stop  = 1'b1;
          start = 1'b1;
          push_ev(K_RST, cyc + 1, 0);
          @(negedge clk);
          stop  = 1'b0;
          start = 1'b0;
          chk("stop_busy", busy, 0);
          chk("stop_idx", seg_idx, 0);
          chk("stop_done", done, 0);
          repeat (3) @(negedge clk);
          chk("stop_stays_idle", busy, 0);
          return;
        end
        if (wr_test && idx == 0 && i == 0) begin
          cfg_we    = 1'b1;
          cfg_addr  = (SEG_AW+2)'(4);
          cfg_wdata = 32'h1234_0000;
          m_ofs[1]  = PW'(32'h1234_0000);
        end
        if (i < 2)                  td = 1'b1;
        else if (segs == stop_after) td = 1'b0;
        else                         td = ($urandom_range(2) != 0);
        trig_done = td;
        if (i >= 2 && td) begin
          cnt++;
          if (cnt == ncy) term = 1'b1;
        end
        i++;
      end
      c = cyc;
      segs++;
      if (idx + 1 < len) begin
        idx++;
        push_ev(K_RST, c + 2, 0);
        push_ev(K_ARM, c + 3, idx);
        a = c + 3;
      end else if (lp) begin
        idx = 0;
        push_ev(K_RST, c + 2, 0);
        push_ev(K_ARM, c + 3, 0);
        a = c + 3;
      end else begin
        push_ev(K_DONE, c + 1, 0);
        @(negedge clk);
        trig_done = 1'b0;
        wait_cyc(c + 2);
        chk("busy_after_done", busy, 0);
        return;
      end
      @(negedge clk);
      trig_done = 1'b0;
      cfg_we    = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ofs"}, set_ofs, 0);
    chk({tag, "_size"}, set_size, 0);
    chk({tag, "_step"}, set_step, 0);
    chk({tag, "_rst"}, set_rst, 0);
    chk({tag, "_trig"}, trig_sw, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_idx"}, seg_idx, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int len, a;
    bit lp;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single segment from the plan
    set_seg(0, '0, 30'h3FFF_FFFF, 30'h0001_0000, 2);
    run_seq(1, 1'b0, -1, 1'b0);

    // Three segments, ncyc 1/3/2
    set_seg(0, PW'($urandom), PW'($urandom), PW'($urandom), 1);
    set_seg(1, PW'($urandom), PW'($urandom), PW'($urandom), 3);
    set_seg(2, PW'($urandom), PW'($urandom), PW'($urandom), 2);
    run_seq(3, 1'b0, -1, 1'b0);

    // Looping over two segments for five loops, then abort
    run_seq(2, 1'b1, 10, 1'b0);

    // Abort in seg1 RUN with a simultaneous start
    run_seq(3, 1'b0, 1, 1'b0);

    // Zero-length start is ignored
    @(negedge clk);
    seq_len = '0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("len0_idle", busy, 0);
    end

    // ncyc of zero behaves as one
    set_seg(0, PW'($urandom), PW'($urandom), PW'($urandom), 0);
    set_seg(1, PW'($urandom), PW'($urandom), PW'($urandom), 0);
    run_seq(2, 1'b0, -1, 1'b0);

    // Live rewrite of seg1 offset during seg0 RUN
    set_seg(1, 30'h0000_AAAA, PW'($urandom), PW'($urandom), 1);
    run_seq(2, 1'b0, -1, 1'b1);

    // Randomized tables and lengths
    for (int k = 0; k < 6; k++) begin
      for (int s = 0; s < NSEG; s++)
        set_seg(s, PW'($urandom), PW'($urandom), PW'($urandom), $urandom_range(3));
      len = $urandom_range(1, NSEG);
      lp  = (k % 3 == 2);
      run_seq(len, lp, lp ? len * 2 : -1, 1'b0);
    end

    // Asynchronous reset in the middle of RUN
    set_seg(0, PW'($urandom) | 30'h1, PW'($urandom), PW'($urandom), 1000);
    @(negedge clk);
    seq_len  = 1;
    seq_loop = 1'b0;
    start    = 1'b1;
    push_ev(K_RST, cyc + 2, 0);
    push_ev(K_ARM, cyc + 3, 0);
    a = cyc + 3;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(a + 4);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_idx", seg_idx, 0);
    set_seg(0, PW'($urandom), PW'($urandom), PW'($urandom), 2);
    run_seq(1, 1'b0, -1, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
